dsi_lane_packet_scheduler: RTL and testbench
============================================

# dsi_lane_packet_scheduler

Sits upstream of the per-lane TX FIFOs that feed the DSI lanes controller. Arbitrates between two packet sources: source 0, the HS video stream, and source 1, the command path, which is HS or LP. Stripes the granted packet byte-by-byte across the active data lanes. Writes 9-bit entries {mode_lp, byte} into the four lane FIFOs, so the lane bridges see the whole packet with a consistent LP/HS flag.

## Interface
- No parameters; lane count fixed at 4, entry width fixed at 9.
- clk_phy  in  1  lane/phy clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  allow new grants; typically lines_ready & clock_ready
- reg_lanes_number  in  3  active lanes 1..4; 0 → 1; 5..7 → 4
- src0_valid / src0_ready  in / out  1  HS video word handshake
- src0_data  in  32  byte 0 = [7:0], sent first
- src0_last  in  1  final word of packet
- src0_bytes  in  3  valid bytes on last word, 1..4; 0 → 4; ignored on non-last words
- src1_valid / src1_ready / src1_data / src1_last / src1_bytes  same as src0, command source
- src1_lp  in  1  packet mode; sampled at grant
- lane_fifo_wdata  out  36  lane i = [i*9+:9] = {mode_lp, byte}
- lane_fifo_write  out  4  per-lane write strobe
- lane_fifo_full  in  4  per-lane full flag
- busy  out  1  state != IDLE

## Operation
- State machine:
  - IDLE → SEND on grant. Grant requires enable & (src0_valid | src1_valid).
  - SEND → FLUSH on accepting a word with last=1.
  - FLUSH → IDLE when byte count = 0 and no beat is emitted this cycle.
- Arbitration is round-robin with a last_grant register, reset to 1, so src0 wins the first tie. A single requester always wins. The grant latches, along with:
  - lp = src0 ? 0 : src1_lp
  - N_eff = lp ? 1 : clamp(reg_lanes_number)
- LP packets always use lane 0 only.
- Byte buffer: 8 bytes plus count 0..8; byte 0 is the oldest.
- Accept rules:
  - srcX_ready = (state == SEND) & (grant == X) & (count <= 4).
  - An accepted word appends 4 bytes, or srcX_bytes on last.
- Beat rules:
  - A beat is emitted when (count >= N_eff, or FLUSH with count > 0) and lane_fifo_full[0..n-1] are all 0.
  - n = min(N_eff, count).
  - Buffer byte k goes to lane k for k < n, each with the latched lp bit; lanes ≥ n get write = 0.
- count_next = count − n·emit + bytes·accept, all in the same cycle.
- Every packet starts on lane 0. The final beat may be partial, writing lanes 0..k−1 only.
- enable low blocks new grants only; an in-flight packet completes.
- src valid low mid-packet stalls SEND indefinitely; there is no timeout.

## Timing
- Reset values:
  - state IDLE, count 0, last_grant 1
  - src0_ready = src1_ready = 0
  - lane_fifo_write = 0, lane_fifo_wdata = 0, busy = 0
- Grant happens in the IDLE cycle; ready can assert from the next cycle. Packets are separated by at least one IDLE cycle.
- lane_fifo_write/wdata are combinational from registered buffer state and lane_fifo_full. A word accepted in cycle t can be written in cycle t+1.
- Full throughput at 4 lanes: one word per cycle with count steady at 4. At 1 lane: one word per 4 cycles.
- A full flag on any of lanes 0..n−1 stalls the whole beat; no lane is written alone.
- Reset asserted mid-packet clears all state and discards the partial packet. The source must restart the packet.
- reg_lanes_number changes take effect at the next grant only.

## Test plan
- 4 lanes; src0 sends 3 words 0x03020100, 0x07060504, 0x0B0A0908, last bytes=4 → three beats on cycles t+1..t+3; lane k receives bytes k, k+4, k+8, all with lp=0; busy drops after FLUSH.
- 2 lanes; src0 sends 2 words, last bytes=1 (5 bytes 0x00..0x04) → beats {00,01}, {02,03}, then lane 0 only {04}; lane_fifo_write = 0011, 0011, 0001.
- src1 with src1_lp=1 and reg_lanes_number=4, 1 word 0xDDCCBBAA → lane 0 receives AA, BB, CC, DD with bit 8 = 1; lane_fifo_write never sets bits 3:1.
- Both sources valid continuously → grants alternate src0, src1, src0 starting with src0; packets never interleave in the FIFOs.
- 4 lanes; lane_fifo_full[2] held high for 5 cycles mid-packet → no writes on any lane for those cycles, src0_ready drops once count > 4, no byte lost or duplicated; then rst pulsed mid-packet → all outputs 0 and state IDLE immediately.

Source files
------------

// File: rtl/dsi_lane_packet_scheduler_if.sv
// Handshake bundle between the packet sources, the scheduler and the four
// per-lane TX FIFOs.
interface dsi_lane_packet_scheduler_if;
    logic        src0_valid;
    logic        src0_ready;
    logic [31:0] src0_data;
    logic        src0_last;
    logic [2:0]  src0_bytes;

    logic        src1_valid;
    logic        src1_ready;
    logic [31:0] src1_data;
    logic        src1_last;
    logic [2:0]  src1_bytes;
    logic        src1_lp;

    logic [35:0] lane_fifo_wdata;
    logic [3:0]  lane_fifo_write;
    logic [3:0]  lane_fifo_full;

    // Scheduler view: consumes source words, produces lane FIFO writes.
    modport slave (
        input  src0_valid, src0_data, src0_last, src0_bytes,
        output src0_ready,
        input  src1_valid, src1_data, src1_last, src1_bytes, src1_lp,
        output src1_ready,
        output lane_fifo_wdata, lane_fifo_write,
        input  lane_fifo_full
    );

    // Environment view: drives the sources and models the lane FIFOs.
    modport master (
        output src0_valid, src0_data, src0_last, src0_bytes,
        input  src0_ready,
        output src1_valid, src1_data, src1_last, src1_bytes, src1_lp,
        input  src1_ready,
        input  lane_fifo_wdata, lane_fifo_write,
        output lane_fifo_full
    );
endinterface

// File: rtl/dsi_lane_packet_scheduler.sv
// Round-robin packet scheduler for the DSI lanes: grants one of two sources,
// buffers up to 8 bytes and stripes them across 1..4 lane FIFOs as
// {mode_lp, byte} entries. LP packets are always sent on lane 0 alone.
module dsi_lane_packet_scheduler (
    input  logic                          clk_phy,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [2:0]                    reg_lanes_number,
    output logic                          busy,
    dsi_lane_packet_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

    state_t      state, state_next;
    logic        grant, last_grant, lp;
    logic [2:0]  n_eff;
    logic [3:0]  count, count_next;
    logic [7:0]  buffer [8];
    logic [7:0]  buffer_next [8];

    logic        do_grant, grant_win;
    logic [2:0]  lanes_clamped;
    logic        ready0, ready1;
    logic        sel_valid, sel_last, accept;
    logic [31:0] sel_data;
    logic [2:0]  sel_bytes;
    logic [3:0]  acc_bytes;
    logic [3:0]  n_take, shift, rem, pos;
    logic [3:0]  lane_in_beat;
    logic        want_beat, full_hit, emit;

    assign busy           = (state != IDLE);
    assign ready0         = (state == SEND) && !grant && (count <= 4'd4);
    assign ready1         = (state == SEND) &&  grant && (count <= 4'd4);
    assign bus.src0_ready = ready0;
    assign bus.src1_ready = ready1;

    // Grant decision and lane-count clamping for the packet about to start.
    always_comb begin
        lanes_clamped = reg_lanes_number;
        if (reg_lanes_number == 3'd0)
            lanes_clamped = 3'd1;
        else if (reg_lanes_number > 3'd4)
            lanes_clamped = 3'd4;
        do_grant  = (state == IDLE) && enable && (bus.src0_valid || bus.src1_valid);
        grant_win = (bus.src0_valid && bus.src1_valid) ? !last_grant : bus.src1_valid;
    end

    // Select the granted source and work out how many bytes a word adds.
    always_comb begin
        sel_valid = grant ? bus.src1_valid : bus.src0_valid;
        sel_data  = grant ? bus.src1_data  : bus.src0_data;
        sel_last  = grant ? bus.src1_last  : bus.src0_last;
        sel_bytes = grant ? bus.src1_bytes : bus.src0_bytes;
        accept    = sel_valid && (grant ? ready1 : ready0);
        acc_bytes = 4'd4;
        if (sel_last && sel_bytes != 3'd0 && sel_bytes <= 3'd4)
            acc_bytes = {1'b0, sel_bytes};
    end

    // Beat formation: a beat writes the oldest n bytes, all lanes or none.
    always_comb begin
        n_take = (count < {1'b0, n_eff}) ? count : {1'b0, n_eff};
        for (int k = 0; k < 4; k++)
            lane_in_beat[k] = (4'(k) < n_take);
        full_hit  = |(bus.lane_fifo_full & lane_in_beat);
        want_beat = (count >= {1'b0, n_eff}) || (state == FLUSH && count != 4'd0);
        emit      = want_beat && !full_hit && (n_take != 4'd0);
        bus.lane_fifo_write = emit ? lane_in_beat : 4'b0000;
        bus.lane_fifo_wdata = '0;
        for (int k = 0; k < 4; k++)
            if (emit && lane_in_beat[k])
                bus.lane_fifo_wdata[k*9 +: 9] = {lp, buffer[k]};
    end

    // Buffer update: drop the emitted bytes, then append the accepted word.
    always_comb begin
        shift      = emit ? n_take : 4'd0;
        rem        = count - shift;
        count_next = rem + (accept ? acc_bytes : 4'd0);
        pos        = 4'd0;
        for (int k = 0; k < 8; k++) begin
            buffer_next[k] = buffer[k];
            if (4'(k) < rem) begin
                buffer_next[k] = buffer[3'(4'(k) + shift)];
            end else if (accept && (4'(k) - rem) < acc_bytes) begin
                pos            = 4'(k) - rem;
                buffer_next[k] = sel_data[{pos[1:0], 3'b000} +: 8];
            end
        end
    end

    // Next-state logic for the packet FSM.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (do_grant) state_next = SEND;
            SEND:    if (accept && sel_last) state_next = FLUSH;
            FLUSH:   if (count == 4'd0 && !emit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_phy or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Latch the winner, its LP mode and lane count at grant time.
    always_ff @(posedge clk_phy or posedge rst) begin
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            lp         <= 1'b0;
            n_eff      <= 3'd1;
        end else if (do_grant) begin
            grant      <= grant_win;
            last_grant <= grant_win;
            lp         <= grant_win && bus.src1_lp;
            n_eff      <= (grant_win && bus.src1_lp) ? 3'd1 : lanes_clamped;
        end
    end

    // Byte buffer and its fill count.
    always_ff @(posedge clk_phy or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
            for (int k = 0; k < 8; k++)
                buffer[k] <= 8'h00;
        end else begin
            count <= count_next;
            for (int k = 0; k < 8; k++)
                buffer[k] <= buffer_next[k];
        end
    end

endmodule

// File: tb/tb_dsi_lane_packet_scheduler.sv
// Testbench for dsi_lane_packet_scheduler: directed cycle checks plus
// randomized traffic compared against a packet-level striping model.
module tb_dsi_lane_packet_scheduler;

    logic       clk_phy;
    logic       rst;
    logic       enable;
    logic [2:0] reg_lanes_number;
    logic       busy;

    dsi_lane_packet_scheduler_if bus ();

    dsi_lane_packet_scheduler dut (
        .clk_phy          (clk_phy),
        .rst              (rst),
        .enable           (enable),
        .reg_lanes_number (reg_lanes_number),
        .busy             (busy),
        .bus              (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Packet store: per source, up to 8 packets of up to 20 bytes.
    int         npkt [2];
    int         plen [2][8];
    logic       plp  [2][8];
    logic [7:0] pdata[2][8][32];

    logic [3:0]  exp_mask_q[$];
    logic [35:0] exp_data_q[$];
    bit stop_all;
    bit mon_done;

    initial begin
        clk_phy = 1'b0;
        forever #5 clk_phy = ~clk_phy;
    end

    task automatic tick();
        @(posedge clk_phy);
        #1;
    endtask

    function automatic int lanes_eff(input int r);
        if (r == 0) return 1;
        if (r > 4) return 4;
        return r;
    endfunction

    function automatic logic [35:0] lane_bits(input logic [3:0] m);
        logic [35:0] r;
        r = '0;
        for (int j = 0; j < 4; j++)
            if (m[j]) r[j*9 +: 9] = 9'h1FF;
        return r;
    endfunction

    function automatic logic [35:0] pack_beat(input logic [7:0] base);
        logic [35:0] r;
        for (int j = 0; j < 4; j++)
            r[j*9 +: 9] = {1'b0, 8'(base + 8'(j))};
        return r;
    endfunction

    task automatic set_src(input int s, input logic v, input logic [31:0] d,
                           input logic l, input logic [2:0] b, input logic lpm);
        if (s == 0) begin
            bus.src0_valid = v; bus.src0_data = d; bus.src0_last = l; bus.src0_bytes = b;
        end else begin
            bus.src1_valid = v; bus.src1_data = d; bus.src1_last = l; bus.src1_bytes = b;
            bus.src1_lp = lpm;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        reg_lanes_number = 3'd4;
        set_src(0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
        set_src(1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
        bus.lane_fifo_full = 4'b0000;
        repeat (2) @(posedge clk_phy);
        #1;
        rst = 1'b0;
        tick();
    endtask

    // Expected beat stream: round-robin order, then each packet striped in
    // chunks of its effective lane count.
    task automatic build_expected(input int lanes);
        int i0, i1, lg, w, p, n, k;
        logic lpm;
        logic [3:0] m;
        logic [35:0] d;
        exp_mask_q.delete();
        exp_data_q.delete();
        i0 = 0; i1 = 0; lg = 1;
        while (i0 < npkt[0] || i1 < npkt[1]) begin
            if (i0 < npkt[0] && i1 < npkt[1]) w = (lg == 1) ? 0 : 1;
            else w = (i0 < npkt[0]) ? 0 : 1;
            lg = w;
            if (w == 0) begin p = i0; i0++; end
            else begin p = i1; i1++; end
            lpm = (w == 1) && plp[1][p];
            n = lpm ? 1 : lanes_eff(lanes);
            for (int off = 0; off < plen[w][p]; off += n) begin
                k = (plen[w][p] - off < n) ? plen[w][p] - off : n;
                m = 4'b0; d = '0;
                for (int j = 0; j < k; j++) begin
                    m[j] = 1'b1;
                    d[j*9 +: 9] = {lpm, pdata[w][p][off + j]};
                end
                exp_mask_q.push_back(m);
                exp_data_q.push_back(d);
            end
        end
    endtask

    task automatic gen_packets(input int n0, input int n1);
        npkt[0] = n0;
        npkt[1] = n1;
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < 8; p++) begin
                plen[s][p] = $urandom_range(20, 1);
                plp[s][p]  = (s == 1) ? 1'($urandom_range(1)) : 1'b0;
                for (int b = 0; b < 32; b++) pdata[s][p][b] = 8'($urandom);
            end
    endtask

    task automatic drive_src(input int s, input int drop_pct);
        int nw, rem;
        logic [31:0] w;
        logic [2:0] b;
        logic v, acc, done;
        for (int p = 0; p < npkt[s]; p++) begin
            nw = (plen[s][p] + 3) / 4;
            for (int wi = 0; wi < nw; wi++) begin
                for (int k = 0; k < 4; k++)
                    w[k*8 +: 8] = (wi*4 + k < plen[s][p]) ? pdata[s][p][wi*4 + k] : 8'($urandom);
                rem = plen[s][p] - 4*(nw - 1);
                if (wi == nw - 1) b = (rem == 4) ? ($urandom_range(1) ? 3'd0 : 3'd4) : 3'(rem);
                else b = 3'($urandom);
                done = 1'b0;
                while (!done && !stop_all) begin
                    v = (wi == 0) || ($urandom_range(99) >= drop_pct);
                    set_src(s, v, w, wi == nw - 1, b, plp[s][p]);
                    @(negedge clk_phy);
                    acc = v && ((s == 0) ? bus.src0_ready : bus.src1_ready);
                    tick();
                    done = acc;
                end
            end
        end
        set_src(s, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic env_driver(input int full_pct, input int en_pct);
        logic [3:0] f;
        while (!mon_done) begin
            for (int k = 0; k < 4; k++) f[k] = ($urandom_range(99) < full_pct);
            bus.lane_fifo_full = f;
            enable = ($urandom_range(99) >= en_pct);
            tick();
        end
        bus.lane_fifo_full = 4'b0000;
        enable = 1'b1;
    endtask

    task automatic monitor_beats();
        int cyc;
        logic [3:0] em;
        logic [35:0] ed;
        cyc = 0;
        while (exp_mask_q.size() > 0 && cyc < 4000 && !stop_all) begin
            @(negedge clk_phy);
            cyc++;
            if (bus.lane_fifo_write != 4'b0000) begin
                em = exp_mask_q.pop_front();
                ed = exp_data_q.pop_front();
                n_checks++;
                if (bus.lane_fifo_write !== em) begin
                    n_fails++;
                    $display("[TB] FAIL beat_write: got %b expected %b", bus.lane_fifo_write, em);
                end
                n_checks++;
                if ((bus.lane_fifo_wdata & lane_bits(em)) !== ed) begin
                    n_fails++;
                    $display("[TB] FAIL beat_data: got %h expected %h", bus.lane_fifo_wdata & lane_bits(em), ed);
                end
                n_checks++;
                if ((bus.lane_fifo_write & bus.lane_fifo_full) !== 4'b0000) begin
                    n_fails++;
                    $display("[TB] FAIL write_into_full: write %b full %b", bus.lane_fifo_write, bus.lane_fifo_full);
                end
            end
        end
        n_checks++;
        if (exp_mask_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL beats_timeout: %0d beats missing, expected 0", exp_mask_q.size());
            stop_all = 1'b1;
        end
        mon_done = 1'b1;
    endtask

    task automatic run_random(input int lanes, input int drop_pct, input int full_pct, input int en_pct);
        int extra;
        do_reset();
        reg_lanes_number = 3'(lanes);
        enable = 1'b1;
        build_expected(lanes);
        stop_all = 1'b0;
        mon_done = 1'b0;
        fork
            drive_src(0, drop_pct);
            drive_src(1, drop_pct);
            env_driver(full_pct, en_pct);
            monitor_beats();
        join
        for (int i = 0; i < 50 && busy; i++) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL busy_after_packets: got %b expected 0", busy);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.lane_fifo_write != 4'b0000) extra++;
            tick();
        end
        n_checks++;
        if (extra != 0) begin
            n_fails++;
            $display("[TB] FAIL extra_beats: got %0d expected 0", extra);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        set_src(0, 1'b1, 32'h11223344, 1'b1, 3'd4, 1'b0);
        set_src(1, 1'b1, 32'h55667788, 1'b1, 3'd4, 1'b1);
        bus.lane_fifo_full = 4'b0000;
        tick();
        n_checks++; if (bus.src0_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ready0: got %b expected 0", bus.src0_ready); end
        n_checks++; if (bus.src1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ready1: got %b expected 0", bus.src1_ready); end
        n_checks++; if (bus.lane_fifo_write !== 4'b0) begin n_fails++; $display("[TB] FAIL reset_write: got %b expected 0", bus.lane_fifo_write); end
        n_checks++; if (bus.lane_fifo_wdata !== 36'h0) begin n_fails++; $display("[TB] FAIL reset_wdata: got %h expected 0", bus.lane_fifo_wdata); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        enable = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL enable_low_blocks: busy %b expected 0", busy); end
        enable = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL grant_on_enable: busy %b expected 1", busy); end
        do_reset();
    endtask

    task automatic test_four_lane();
        logic [31:0] w;
        do_reset();
        reg_lanes_number = 3'd4;
        enable = 1'b1;
        set_src(0, 1'b1, 32'h03020100, 1'b0, 3'd0, 1'b0);
        #1;
        n_checks++; if (bus.src0_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL idle_ready: got %b expected 0", bus.src0_ready); end
        tick();
        #1;
        n_checks++; if (bus.src0_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL send_ready: got %b expected 1", bus.src0_ready); end
        n_checks++; if (bus.lane_fifo_write !== 4'b0) begin n_fails++; $display("[TB] FAIL early_write: got %b expected 0", bus.lane_fifo_write); end
        for (int j = 1; j <= 3; j++) begin
            tick();
            w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
            set_src(0, j < 3, w, j == 2, 3'd4, 1'b0);
            #1;
            n_checks++; if (bus.lane_fifo_write !== 4'b1111) begin n_fails++; $display("[TB] FAIL four_lane_write%0d: got %b expected 1111", j, bus.lane_fifo_write); end
            n_checks++; if (bus.lane_fifo_wdata !== pack_beat(8'(4*(j-1)))) begin n_fails++; $display("[TB] FAIL four_lane_data%0d: got %h expected %h", j, bus.lane_fifo_wdata, pack_beat(8'(4*(j-1)))); end
        end
        tick();
        #1;
        n_checks++; if (bus.lane_fifo_write !== 4'b0 || busy !== 1'b1) begin n_fails++; $display("[TB] FAIL flush_tail: write %b busy %b expected 0000 1", bus.lane_fifo_write, busy); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL busy_drop: got %b expected 0", busy); end
    endtask

    task automatic test_two_lane();
        npkt = '{1, 0};
        plen[0][0] = 5;
        for (int b = 0; b < 5; b++) pdata[0][0][b] = 8'(b);
        run_random(2, 0, 0, 0);
    endtask

    task automatic test_lp_command();
        npkt = '{0, 1};
        plen[1][0] = 4;
        plp[1][0] = 1'b1;
        pdata[1][0][0] = 8'hAA; pdata[1][0][1] = 8'hBB;
        pdata[1][0][2] = 8'hCC; pdata[1][0][3] = 8'hDD;
        run_random(4, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        gen_packets(3, 3);
        run_random(4, 0, 0, 0);
    endtask

    task automatic test_full_stall_and_reset();
        logic [7:0] stream[$];
        logic [31:0] w;
        logic acc;
        int widx;
        do_reset();
        reg_lanes_number = 3'd4;
        enable = 1'b1;
        widx = 0;
        for (int c = 0; c < 40; c++) begin
            bus.lane_fifo_full = (c >= 2 && c <= 6) ? 4'b0100 : 4'b0000;
            for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(8'h10 + 4*widx + k);
            set_src(0, widx < 5, w, widx == 4, 3'd0, 1'b0);
            #1;
            acc = bus.src0_valid && bus.src0_ready;
            for (int k = 0; k < 4; k++)
                if (bus.lane_fifo_write[k]) stream.push_back(bus.lane_fifo_wdata[k*9 +: 8]);
            if (c >= 2 && c <= 6) begin
                n_checks++; if (bus.lane_fifo_write !== 4'b0) begin n_fails++; $display("[TB] FAIL stall_write c%0d: got %b expected 0000", c, bus.lane_fifo_write); end
            end
            if (c == 2) begin
                n_checks++; if (bus.src0_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL stall_ready_c2: got %b expected 1", bus.src0_ready); end
            end
            if (c >= 3 && c <= 6) begin
                n_checks++; if (bus.src0_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL stall_ready c%0d: got %b expected 0", c, bus.src0_ready); end
            end
            if (acc) widx++;
            tick();
        end
        n_checks++; if (stream.size() != 20) begin n_fails++; $display("[TB] FAIL stall_stream_len: got %0d expected 20", stream.size()); end
        for (int i = 0; i < 20 && i < stream.size(); i++) begin
            n_checks++;
            if (stream[i] !== 8'(8'h10 + i)) begin n_fails++; $display("[TB] FAIL stall_byte%0d: got %h expected %h", i, stream[i], 8'(8'h10 + i)); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL stall_busy_end: got %b expected 0", busy); end

        set_src(1, 1'b1, 32'h33221100, 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        set_src(1, 1'b1, 32'h77665544, 1'b0, 3'd0, 1'b0);
        #1;
        n_checks++; if (bus.lane_fifo_write !== 4'b1111) begin n_fails++; $display("[TB] FAIL pre_reset_beat: got %b expected 1111", bus.lane_fifo_write); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.lane_fifo_write !== 4'b0 || bus.lane_fifo_wdata !== 36'h0) begin n_fails++; $display("[TB] FAIL midreset_lanes: write %b wdata %h expected 0", bus.lane_fifo_write, bus.lane_fifo_wdata); end
        n_checks++; if (busy !== 1'b0 || bus.src0_ready !== 1'b0 || bus.src1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL midreset_ctrl: busy %b ready %b%b expected 0", busy, bus.src0_ready, bus.src1_ready); end
        set_src(1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int lane_list[7] = '{0, 1, 2, 3, 4, 5, 7};
        for (int i = 0; i < 7; i++) begin
            gen_packets($urandom_range(4, 1), $urandom_range(4, 1));
            run_random(lane_list[i], 30, 20, 20);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        reg_lanes_number = 3'd4;
        set_src(0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
        set_src(1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
        bus.lane_fifo_full = 4'b0000;
        stop_all = 1'b0;
        mon_done = 1'b0;
        test_reset();
        test_four_lane();
        test_two_lane();
        test_lp_command();
        test_back_to_back();
        test_full_stall_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
